arithmetic_circuits_rca: RTL and testbench

//  Unsigned/two's-complement ripple-carry adder: sum = x + y + cin, one full-adder cell per bit.

---
 rtl/arithmetic_circuits_rca.sv | 60 ++++++
 tb/tb_arithmetic_circuits_rca.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/arithmetic_circuits_rca.sv
// ============================================================================
// Module   : arithmetic_circuits_rca
// Brief    : Ripple-carry adder with combinational result and registered flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arithmetic_circuits_rca #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             zero_q
);

   logic [WIDTH:0] w_c;
   logic           w_ovf_d;
   logic           w_zero_d;

   assign w_c[0] = cin;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
         assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
      end
   endgenerate

   assign cout = w_c[WIDTH];

   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   assign w_ovf_d  = w_c[WIDTH-1] ^ w_c[WIDTH];
   assign w_zero_d = (sum == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         sum_q  <= sum;
         cout_q <= cout;
         ovf_q  <= w_ovf_d;
         zero_q <= w_zero_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_arithmetic_circuits_rca.sv
// ============================================================================
// Module   : tb_arithmetic_circuits_rca
// Brief    : Directed and randomized checks of the ripple-carry adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arithmetic_circuits_rca;

   localparam int W   = 4;
   localparam int MOD = 2 ** W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] x   = '0;
   logic [W-1:0] y   = '0;
   logic         cin = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic [W-1:0] sum_q;
   logic         cout_q;
   logic         ovf_q;
   logic         zero_q;

   int n_cmp = 0;
   int n_err = 0;

   arithmetic_circuits_rca #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .x      (x),
      .y      (y),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q),
      .zero_q (zero_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Signed overflow from the arithmetic value of the operands, not from carries.
   function automatic int ref_ovf(input int a, input int b, input int ci);
      int sa, sb, s;
      sa = (a >= MOD / 2) ? a - MOD : a;
      sb = (b >= MOD / 2) ? b - MOD : b;
      s  = sa + sb + ci;
      return (s > MOD / 2 - 1 || s < -(MOD / 2)) ? 1 : 0;
   endfunction

   // Apply one vector, check the combinational result, then the registered copy.
   task automatic vec(input int a, input int b, input int ci, input int r);
      int e;
      e = a + b + ci;
      @(negedge clk);
      x   = a[W-1:0];
      y   = b[W-1:0];
      cin = ci[0];
      rst = r[0];
      #2;
      chk("comb_sum", {27'd0, cout, sum}, e);
      @(posedge clk);
      #1;
      chk("comb_hold", {27'd0, cout, sum}, e);
      if (r != 0) begin
         chk("rst_sum_q",  sum_q,  0);
         chk("rst_cout_q", cout_q, 0);
         chk("rst_ovf_q",  ovf_q,  0);
         chk("rst_zero_q", zero_q, 0);
      end else begin
         chk("sum_q",  sum_q,  e % MOD);
         chk("cout_q", cout_q, e / MOD);
         chk("ovf_q",  ovf_q,  ref_ovf(a, b, ci));
         chk("zero_q", zero_q, ((e % MOD) == 0) ? 1 : 0);
      end
   endtask

   initial begin
      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_sum_q",  sum_q,  0);
      chk("reset_cout_q", cout_q, 0);
      chk("reset_ovf_q",  ovf_q,  0);
      chk("reset_zero_q", zero_q, 0);

      // Sweep x=y=i, cin=1 -> 2i+1
      for (int i = 0; i < MOD; i++) begin
         vec(i, i, 1, 0);
         $display("sweep %0d: %s", i, ({cout, sum} === 5'(2 * i + 1)) ? "TRUE" : "FALSE");
      end

      // Directed corner cases
      vec(7, 7, 1, 0);
      chk("d2_sum_q", sum_q, 4'hF);
      chk("d2_ovf_q", ovf_q, 1);
      vec(8, 8, 0, 0);
      chk("d3_zero_q", zero_q, 1);
      chk("d3_cout_q", cout_q, 1);
      vec(0, 0, 0, 0);
      chk("d4_zero_q", zero_q, 1);
      chk("d4_ovf_q",  ovf_q,  0);

      // Reset mid-operation on the maximum input
      vec(15, 15, 1, 0);
      vec(15, 15, 1, 1);
      chk("d5_sum",  sum,  4'hF);
      chk("d5_cout", cout, 1);
      vec(15, 15, 1, 0);
      chk("d5_recover_sum_q", sum_q, 4'hF);

      // Exhaustive sweep
      for (int a = 0; a < MOD; a++)
         for (int b = 0; b < MOD; b++)
            for (int c = 0; c < 2; c++)
               vec(a, b, c, 0);

      // Randomized vectors with occasional reset pulses
      for (int k = 0; k < 300; k++)
         vec(int'($urandom_range(MOD - 1, 0)), int'($urandom_range(MOD - 1, 0)),
             int'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0) ? 1 : 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
